// File: rtl/sort_loader_pkg.sv
// Shared types for the sort datapath: address/data words, loader state encoding
// and the Galois LFSR step used to generate the fill pattern.
package sort_loader_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 5;
    localparam int DEPTH_DEF = 32;

    typedef logic [DATA_W-1:0] t_data;
    typedef logic [ADDR_W-1:0] t_addr;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_KICK,
        ST_WAIT,
        ST_FINISH
    } t_ld_state;

    // One right-shift Galois step; the feedback mask applies when a 1 falls out.
    function automatic t_data galois_step(input t_data s, input t_data taps);
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/sort_loader_if.sv
// Memory write port plus start/done handshake between the loader (master)
// and the sort controller / memory side (slave).
interface sort_loader_if;
    import sort_loader_pkg::*;

    logic  wr_en;
    t_addr wr_addr;
    t_data wr_data;
    logic  start;
    logic  sort_done;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  sort_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output sort_done
    );

endinterface

// File: rtl/sort_lfsr.sv
// Galois LFSR with synchronous load and advance enable; load has priority.
module sort_lfsr
    import sort_loader_pkg::*;
#(
    parameter t_data TAPS    = 16'hB400,
    parameter t_data RST_VAL = 16'hACE1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  t_data load_val,
    input  logic  en,
    output t_data state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_VAL;
        end else if (load) begin
            state <= load_val;
        end else if (en) begin
            state <= galois_step(state, TAPS);
        end
    end

endmodule

// File: rtl/sort_loader.sv
// Fills the sort memory with a seeded LFSR pattern, kicks the sorter and waits
// for a fresh done. Optional running checksum with SORT_LOADER_CHECKSUM_EN.
module sort_loader
    import sort_loader_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEF,
    parameter logic [15:0] DEF_SEED = 16'hACE1,
    parameter t_data       TAPS     = 16'hB400
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  t_data         seed,
    sort_loader_if.master bus,
    output logic          busy,
    output logic          all_done
`ifdef SORT_LOADER_CHECKSUM_EN
    ,
    output t_data         checksum
`endif
);

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  LAST       = CNT_W'(DEPTH - 1);
    localparam t_data             DEF_SEED_T = t_data'(DEF_SEED);

    t_ld_state        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             arm_q;
    logic             go_ok;
    t_data            lfsr_q;
    t_data            load_val;

    assign go_ok    = go && (state_q == ST_IDLE || state_q == ST_FINISH);
    assign load_val = (seed == '0) ? DEF_SEED_T : seed;

    sort_lfsr #(
        .TAPS    (TAPS),
        .RST_VAL (DEF_SEED_T)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (go_ok),
        .load_val (load_val),
        .en       (state_q == ST_FILL),
        .state    (lfsr_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FINISH: if (go) state_d = ST_FILL;
            ST_FILL:            if (cnt_q == LAST) state_d = ST_KICK;
            ST_KICK:            state_d = ST_WAIT;
            // Only a low-then-high done sequence after the kick counts.
            ST_WAIT:            if (arm_q && bus.sort_done) state_d = ST_FINISH;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            arm_q       <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.start   <= 1'b0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (go_ok) begin
                cnt_q <= '0;
            end else if (state_q == ST_FILL && cnt_q != LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (go_ok || state_q == ST_KICK) begin
                arm_q <= 1'b0;
            end else if (state_q == ST_WAIT && !bus.sort_done) begin
                arm_q <= 1'b1;
            end

            // Write port lags the state by one cycle and idles at zero outside FILL.
            bus.wr_en   <= (state_q == ST_FILL);
            bus.wr_addr <= (state_q == ST_FILL) ? t_addr'(cnt_q) : '0;
            bus.wr_data <= (state_q == ST_FILL) ? lfsr_q : '0;
            bus.start   <= (state_q == ST_KICK);

            busy     <= (state_d == ST_FILL || state_d == ST_KICK || state_d == ST_WAIT);
            all_done <= (state_d == ST_FINISH);
        end
    end

`ifdef SORT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || go_ok) begin
            checksum <= '0;
        end else if (state_q == ST_FILL) begin
            checksum <= checksum + lfsr_q;
        end
    end
`endif

endmodule
